// File: rtl/tile_rom_arbiter_if.sv
// Tile ROM arbiter bus: requester handshake, ROM port and tagged return path.
// slave  = the arbiter's view; master = the requesters/ROM side.
interface tile_rom_arbiter_if #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 16
);
  localparam int IDX_W  = $clog2(BURST_LEN);
  localparam int CODE_W = ADDR_W - IDX_W;

  // Requester side
  logic [1:0]        req;
  logic [CODE_W-1:0] tile_code0;
  logic [CODE_W-1:0] tile_code1;
  logic [1:0]        gnt;
  logic              busy;

  // Tile ROM port
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_en;
  logic [DATA_W-1:0] rom_data;

  // Tagged return stream
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_owner;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_last;

  modport slave (
    input  req, tile_code0, tile_code1, rom_data,
    output gnt, busy, rom_addr, rom_en,
    output rd_valid, rd_data, rd_owner, rd_idx, rd_last
  );

  modport master (
    output req, tile_code0, tile_code1, rom_data,
    input  gnt, busy, rom_addr, rom_en,
    input  rd_valid, rd_data, rd_owner, rd_idx, rd_last
  );
endinterface

// File: rtl/tile_rom_arbiter.sv
// Shares one single-port tile ROM between two tile fetchers. A requester asks
// for a whole tile by code; the winner (round-robin on contention) gets
// BURST_LEN consecutive reads, and every returned byte is tagged with owner,
// index and last flag so requesters keep no address counters of their own.
// The interface instance must be built with the same ADDR_W/DATA_W/BURST_LEN.
module tile_rom_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 16,
  parameter int RD_LAT    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  tile_rom_arbiter_if.slave   bus
);
  localparam int IDX_W  = $clog2(BURST_LEN);
  localparam int CODE_W = ADDR_W - IDX_W;
  // Return-pipe payload: {valid, owner, idx, last}
  localparam int PW     = IDX_W + 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    cnt_reg, cnt_next;
  logic                rr_ptr_reg, rr_ptr_next;
  logic                owner_reg, owner_next;
  logic [CODE_W-1:0]   code_reg, code_next;
  logic [RD_LAT*PW-1:0] pipe_reg, pipe_next;

  logic                winner;
  logic [1:0]          gnt_sig;
  logic                rom_en_sig;
  logic [PW-1:0]       pipe_src;
  logic [PW-1:0]       pipe_out;

  // State, counter, arbitration pointer, latched request and return pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      rr_ptr_reg <= 1'b0;
      owner_reg  <= 1'b0;
      code_reg   <= '0;
      pipe_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      rr_ptr_reg <= rr_ptr_next;
      owner_reg  <= owner_next;
      code_reg   <= code_next;
      pipe_reg   <= pipe_next;
    end
  end

  // Arbitration, burst sequencing and per-cycle burst outputs.
  // cnt holds at LAST_IDX after a burst so rom_addr keeps its last value in IDLE.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    rr_ptr_next = rr_ptr_reg;
    owner_next  = owner_reg;
    code_next   = code_reg;
    winner      = 1'b0;
    gnt_sig     = 2'b00;
    rom_en_sig  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (|bus.req) begin
          // Both asking: the pointer decides; otherwise the lone requester wins.
          winner      = (bus.req == 2'b11) ? rr_ptr_reg : bus.req[1];
          owner_next  = winner;
          code_next   = winner ? bus.tile_code1 : bus.tile_code0;
          cnt_next    = '0;
          rr_ptr_next = ~winner;
          state_next  = ST_BURST;
        end
      end
      ST_BURST: begin
        rom_en_sig = 1'b1;
        if (cnt_reg == '0) begin
          gnt_sig[owner_reg] = 1'b1;
        end
        if (cnt_reg == LAST_IDX) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + IDX_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Tag accompanying each ROM access, delayed to line up with rom_data.
  assign pipe_src = {rom_en_sig, owner_reg, cnt_reg,
                     rom_en_sig & (cnt_reg == LAST_IDX)};

  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        assign pipe_next[gi*PW +: PW] = pipe_src;
      end else begin : g_tail
        assign pipe_next[gi*PW +: PW] = pipe_reg[(gi-1)*PW +: PW];
      end
    end
  endgenerate

  assign pipe_out = pipe_reg[(RD_LAT-1)*PW +: PW];

  // Burst-side outputs; the tile code sits above the byte counter, so the
  // counter can never carry into the code bits.
  assign bus.gnt      = gnt_sig;
  assign bus.busy     = rom_en_sig;
  assign bus.rom_en   = rom_en_sig;
  assign bus.rom_addr = {code_reg, cnt_reg};

  // Return path: tags from the pipe, data straight from the ROM.
  assign bus.rd_valid = pipe_out[PW-1];
  assign bus.rd_owner = pipe_out[PW-2];
  assign bus.rd_idx   = pipe_out[IDX_W:1];
  assign bus.rd_last  = pipe_out[0];
  assign bus.rd_data  = bus.rom_data;

endmodule

// File: doc/tile_rom_arbiter.md
Name: tile_rom_arbiter

Overview:
- Shares the single-port tile ROM (4 KB, 12-bit address, 8-bit data, 1-cycle read latency) between two tile fetch requesters, e.g. the background tilemap fetcher and the sprite/debug fetcher.
- A requester asks for one whole tile by tile code; the block arbitrates round-robin and sequences BURST_LEN consecutive ROM reads.
- Each returned byte is tagged with owner, index and last flag, so requesters need no address counters.

Parameters:
- ADDR_W, 12, tile ROM address width.
- DATA_W, 8, tile ROM data width.
- BURST_LEN, 16, bytes per tile (8x8, 2bpp). Must be a power of two. IDX_W = log2(BURST_LEN).
- RD_LAT, 1, ROM read latency in cycles (>=1).

Ports:
- clk  in  1  system clock, all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  2  per-requester tile request. Level; held until the matching gnt.
- tile_code0  in  ADDR_W-IDX_W  requester 0 tile code, valid while req[0].
- tile_code1  in  ADDR_W-IDX_W  requester 1 tile code, valid while req[1].
- gnt  out  2  one-hot, one-cycle pulse; the tile code was captured.
- busy  out  1  burst in progress.
- rom_addr  out  ADDR_W  to tile ROM addra.
- rom_en  out  1  to tile ROM ena.
- rom_data  in  DATA_W  from tile ROM douta.
- rd_valid  out  1  rd_data is valid this cycle.
- rd_data  out  DATA_W  returned byte (pass-through of rom_data).
- rd_owner  out  1  requester the byte belongs to.
- rd_idx  out  IDX_W  byte index within the tile.
- rd_last  out  1  high with the byte at rd_idx == BURST_LEN-1.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cnt=0, rr_ptr=0 (requester 0 favoured), latency pipe cleared. gnt=0, busy=0, rom_en=0, rom_addr=0, rd_valid=0, rd_owner=0, rd_idx=0, rd_last=0. Takes effect immediately, including mid-burst; no bytes are delivered from an aborted burst.
- FSM states: IDLE, BURST.
- IDLE, no req: remain in IDLE.
- IDLE, at least one req at a posedge: choose the winner.
  - Only one requesting: it wins.
  - Both requesting: requester rr_ptr wins.
  - Latch owner and tile_code of the winner; cnt=0; rr_ptr = ~winner; go to BURST.
- BURST outputs, every cycle:
  - rom_en=1, busy=1.
  - rom_addr = {latched_code, cnt}; code in upper ADDR_W-IDX_W bits, cnt in lower IDX_W bits.
  - gnt[owner]=1 only in the first BURST cycle (cnt==0).
- BURST transitions: cnt increments each posedge. At the posedge where cnt==BURST_LEN-1, go to IDLE.
  - One burst is exactly BURST_LEN rom_en cycles.
  - Mandatory one IDLE cycle between bursts, so back-to-back grants are BURST_LEN+1 cycles apart.
- In IDLE, rom_en=0, busy=0, and rom_addr holds its last value.
- Request semantics:
  - req is not sampled during BURST.
  - A req dropped before its gnt is forgotten.
  - A req still high after its gnt is treated as a new request at the next IDLE cycle.
- Return path: {rom_en, owner, cnt, cnt==BURST_LEN-1} is delayed RD_LAT cycles through a register pipe and drives rd_valid, rd_owner, rd_idx, rd_last.
  - rd_data = rom_data, unregistered, aligned with rd_valid.
  - With RD_LAT=1, the first byte appears the cycle after gnt.
- rd_owner, rd_idx and rd_last are don't-care when rd_valid=0, but the bench checks the reset values.
- Address wrap: cnt never carries into the tile-code bits. Tile code max (all ones) reads the top BURST_LEN bytes of the ROM.

Test Plan:
- Single burst: after reset, req=01, tile_code0=0x05 -> gnt=01 for one cycle; rom_addr 0x050..0x05F over 16 consecutive rom_en cycles; rd_valid 16 cycles starting 1 cycle later; rd_owner=0, rd_idx 0..15, rd_last only at idx 15, rd_data matches ROM model.
- Contention: req=11 from reset with codes 0x12/0x34 -> requester 0 first (0x120..0x12F); then one idle cycle; then requester 1 (0x340..0x34F); a third simultaneous request goes to requester 0.
- Held request: req[1] held high with code 0xFF -> grants every 17 cycles; addrs 0xFF0..0xFFF with no carry; busy low exactly one cycle between bursts.
- Dropped request: req[0] pulsed for 1 cycle while a requester 1 burst is active -> no gnt[0] and no owner-0 data ever.
- Reset mid-burst: rst_n=0 at cnt==7 -> all outputs 0 immediately, rd_valid stays 0 through release; the next req=10 gets a full 16-byte burst from idx 0, granted to requester 1 since rr_ptr reset favours 0 only on contention.
- Latency parameter: RD_LAT=2 with ROM model latency 2 -> rd_valid first asserts 2 cycles after gnt; data and rd_idx stay aligned for all 16 bytes.
